// File: rtl/bac_io_arbiter_if.sv
// BAC-02 peripheral bus bundle: CPU side, aux masters A/B, peripheral decoder side and conflict counters.
// slave = arbiter view, master = everything around it (CPU, A, B, peripheral decoder).
interface bac_io_arbiter_if #(
    parameter int CNT_W = 8
);
    logic [7:0]       cpu_addr;
    logic [7:0]       cpu_dout;
    logic             cpu_out;
    logic             cpu_in;
    logic [7:0]       cpu_din;

    logic             a_req;
    logic             a_we;
    logic [7:0]       a_addr;
    logic [7:0]       a_wdata;
    logic             a_ack;
    logic [7:0]       a_rdata;

    logic             b_req;
    logic             b_we;
    logic [7:0]       b_addr;
    logic [7:0]       b_wdata;
    logic             b_ack;
    logic [7:0]       b_rdata;

    logic [7:0]       p_addr;
    logic [7:0]       p_dout;
    logic             p_out;
    logic             p_in;
    logic [7:0]       p_din;

    logic [CNT_W-1:0] a_conflicts;
    logic [CNT_W-1:0] b_conflicts;

    modport slave (
        input  cpu_addr, cpu_dout, cpu_out, cpu_in,
        output cpu_din,
        input  a_req, a_we, a_addr, a_wdata,
        output a_ack, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_ack, b_rdata,
        output p_addr, p_dout, p_out, p_in,
        input  p_din,
        output a_conflicts, b_conflicts
    );

    modport master (
        output cpu_addr, cpu_dout, cpu_out, cpu_in,
        input  cpu_din,
        output a_req, a_we, a_addr, a_wdata,
        input  a_ack, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_ack, b_rdata,
        input  p_addr, p_dout, p_out, p_in,
        output p_din,
        input  a_conflicts, b_conflicts
    );
endinterface

// File: rtl/bac_io_arbiter.sv
// BAC-02 peripheral bus arbiter: CPU strobes pass through with zero latency and always win; aux masters A/B
// are granted in CPU-idle cycles (round-robin or A-first) and acked one cycle after grant, at most every 2nd cycle.
module bac_io_arbiter #(
    parameter bit RR_EN = 1'b1,
    parameter int CNT_W = 8
) (
    input  logic         clk,
    input  logic         reset,
    bac_io_arbiter_if.slave bus
);

    // GRANT is the combinational phase of an IDLE master that wins the bus; only the ACK phase is stored.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ACK  = 1'b1;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             cpu_own;
    logic             a_elig;
    logic             b_elig;
    logic             a_gnt;
    logic             b_gnt;

    logic [0:0]       a_st_q;
    logic [0:0]       a_st_d;
    logic [0:0]       b_st_q;
    logic [0:0]       b_st_d;
    logic             last_q;
    logic             last_d;
    logic [7:0]       a_rdata_q;
    logic [7:0]       a_rdata_d;
    logic [7:0]       b_rdata_q;
    logic [7:0]       b_rdata_d;
    logic [CNT_W-1:0] a_cnt_q;
    logic [CNT_W-1:0] a_cnt_d;
    logic [CNT_W-1:0] b_cnt_q;
    logic [CNT_W-1:0] b_cnt_d;

    always_comb begin
        cpu_own = bus.cpu_in | bus.cpu_out;
        a_elig  = bus.a_req & (a_st_q == ST_IDLE) & ~reset;
        b_elig  = bus.b_req & (b_st_q == ST_IDLE) & ~reset;
        a_gnt   = 1'b0;
        b_gnt   = 1'b0;
        if (!cpu_own) begin
            if (a_elig && b_elig) begin
                if (RR_EN && (last_q == SEL_A)) begin
                    b_gnt = 1'b1;
                end else begin
                    a_gnt = 1'b1;
                end
            end else begin
                a_gnt = a_elig;
                b_gnt = b_elig;
            end
        end
    end

    // A CPU with both strobes high is passed through as-is; it is a CPU fault, not ours to fix.
    always_comb begin
        bus.p_addr = 8'h00;
        bus.p_dout = 8'h00;
        bus.p_out  = 1'b0;
        bus.p_in   = 1'b0;
        if (cpu_own) begin
            bus.p_addr = bus.cpu_addr;
            bus.p_dout = bus.cpu_dout;
            bus.p_out  = bus.cpu_out;
            bus.p_in   = bus.cpu_in;
        end else if (a_gnt) begin
            bus.p_addr = bus.a_addr;
            bus.p_dout = bus.a_wdata;
            bus.p_out  = bus.a_we;
            bus.p_in   = ~bus.a_we;
        end else if (b_gnt) begin
            bus.p_addr = bus.b_addr;
            bus.p_dout = bus.b_wdata;
            bus.p_out  = bus.b_we;
            bus.p_in   = ~bus.b_we;
        end
        bus.cpu_din = bus.p_din;
    end

    always_comb begin
        a_st_d    = a_gnt ? ST_ACK : ST_IDLE;
        b_st_d    = b_gnt ? ST_ACK : ST_IDLE;
        a_rdata_d = (a_gnt && !bus.a_we) ? bus.p_din : a_rdata_q;
        b_rdata_d = (b_gnt && !bus.b_we) ? bus.p_din : b_rdata_q;

        last_d = last_q;
        if (a_gnt) begin
            last_d = SEL_A;
        end else if (b_gnt) begin
            last_d = SEL_B;
        end

        // Only cycles where the CPU actually stole the bus from a ready master are counted.
        a_cnt_d = a_cnt_q;
        b_cnt_d = b_cnt_q;
        if (a_elig && cpu_own && (a_cnt_q != CNT_MAX)) begin
            a_cnt_d = a_cnt_q + CNT_ONE;
        end
        if (b_elig && cpu_own && (b_cnt_q != CNT_MAX)) begin
            b_cnt_d = b_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_st_q    <= ST_IDLE;
            b_st_q    <= ST_IDLE;
            last_q    <= SEL_B;
            a_rdata_q <= 8'h00;
            b_rdata_q <= 8'h00;
            a_cnt_q   <= '0;
            b_cnt_q   <= '0;
        end else begin
            a_st_q    <= a_st_d;
            b_st_q    <= b_st_d;
            last_q    <= last_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
            a_cnt_q   <= a_cnt_d;
            b_cnt_q   <= b_cnt_d;
        end
    end

    always_comb begin
        bus.a_ack       = (a_st_q == ST_ACK);
        bus.b_ack       = (b_st_q == ST_ACK);
        bus.a_rdata     = a_rdata_q;
        bus.b_rdata     = b_rdata_q;
        bus.a_conflicts = a_cnt_q;
        bus.b_conflicts = b_cnt_q;
    end

endmodule

// File: doc/bac_io_arbiter.md
Name: bac_io_arbiter

Overview:
Shares the BAC-02 8-bit peripheral bus (addr/dout/out/in/din) between the CPU core and two auxiliary bus masters, A (program loader / debug UART) and B (screen/DMA fetcher). The CPU cannot stall, so its in/out cycles always win. Auxiliary masters use a req/ack handshake and are served in CPU-idle cycles, round-robin. The block sits between the CPU and the peripheral address decoder.

Parameters:
RR_EN, 1, 1 = round-robin between A and B; 0 = fixed priority, A over B
CNT_W, 8, width of the saturating conflict counters

Ports:
clk  in  1  system clock
reset  in  1  reset, asynchronous, active-high
cpu_addr  in  8  CPU peripheral address
cpu_dout  in  8  CPU write data
cpu_out  in  1  CPU write strobe, one cycle
cpu_in  in  1  CPU read strobe, one cycle
cpu_din  out  8  read data to CPU, combinational
a_req  in  1  master A request level
a_we  in  1  master A: 1 = write, 0 = read
a_addr  in  8  master A address
a_wdata  in  8  master A write data
a_ack  out  1  master A transaction done, one-cycle pulse
a_rdata  out  8  master A read data, valid with a_ack
b_req, b_we, b_addr, b_wdata, b_ack, b_rdata  same as A, for master B
p_addr  out  8  peripheral address
p_dout  out  8  peripheral write data
p_out  out  1  peripheral write strobe
p_in  out  1  peripheral read strobe
p_din  in  8  peripheral read data, combinational, same cycle as p_in
a_conflicts  out  CNT_W  saturating count of cycles A was pending and blocked by the CPU
b_conflicts  out  CNT_W  same, for B

Behaviour:
- Bus owner per cycle is combinational:
  - CPU if cpu_in|cpu_out.
  - Otherwise the selected eligible auxiliary master.
  - Otherwise none.
- CPU cycle: p_addr=cpu_addr, p_dout=cpu_dout, p_out=cpu_out, p_in=cpu_in, cpu_din=p_din. Zero added latency.
- cpu_in and cpu_out both high: pass both through unchanged. This is a CPU fault and is not arbitrated.
- Eligibility: master X is eligible when X_req=1 and X is not in flight.
- In flight: granted in cycle N, with ack pending in cycle N+1.
- Grant cycle N for X:
  - p_addr=X_addr, p_dout=X_wdata.
  - p_out=X_we, p_in=~X_we, single-cycle strobe.
- Cycle N+1:
  - X_ack=1.
  - X_rdata = p_din registered at the grant edge (read), or unchanged (write).
- Master holds req/we/addr/wdata stable until ack. Sampling ack and keeping req=1 starts a new transaction; earliest grant is cycle N+2, so at most one transaction every 2 cycles per master.
- Round-robin (RR_EN=1):
  - Register last_grant, reset value B, so A wins the first tie.
  - Both eligible: grant the one not equal to last_grant.
  - last_grant updates only on auxiliary grants.
- RR_EN=0: A always wins ties.
- Idle cycle (no owner): p_addr=0, p_dout=0, p_out=0, p_in=0. cpu_din=p_din always.
- Conflict counters: X_conflicts increments when X is eligible and the CPU owns the bus. Saturates at all-ones and never wraps.
- X_req dropping before grant: request is abandoned, no ack.
- X_req dropping while in flight: ack is still produced.
- Reset (async, any time, including mid-transaction):
  - a_ack=b_ack=0, a_rdata=b_rdata=0.
  - In-flight flags cleared; the interrupted transaction gets no ack.
  - last_grant=B, counters=0.
  - Bus outputs follow the combinational rules above, with aux grants suppressed while reset=1.
- State per master: IDLE -> GRANT (eligible and selected) -> ACK (unconditional next cycle) -> IDLE. A may be in ACK while B is in GRANT in the same cycle.

Test Plan:
1. A read, bus idle: a_req=1, a_we=0, a_addr=8'h10, p_din=8'h5A -> p_in=1 with p_addr=8'h10 in cycle N; a_ack=1, a_rdata=8'h5A in N+1; next grant no earlier than N+2.
2. CPU priority: cpu_out=1, cpu_addr=8'h20, cpu_dout=8'h77 while A pending -> p_out=1, p_addr=8'h20, p_dout=8'h77; A granted the first CPU-idle cycle; a_conflicts=1.
3. Round-robin: A and B both held requesting, CPU idle -> grants A, B, A, B on consecutive cycles; each ack exactly one cycle after its grant. With RR_EN=0: A, B, A, B is still seen because A is ineligible during its ack cycle, and B never starves.
4. Write: b_req=1, b_we=1, b_addr=8'hF0, b_wdata=8'h3C -> p_out=1, p_dout=8'h3C for one cycle; b_ack next cycle; b_rdata unchanged.
5. Saturation: A pending with the CPU strobing every cycle for 300 cycles, CNT_W=8 -> a_conflicts=8'hFF, no wrap.
6. Reset mid-transaction: assert reset in A's grant cycle -> a_ack never pulses; counters=0; after release with a_req=1, A is granted first and operates normally.
